sprite_pixel_serializer: RTL and testbench

- Sits directly upstream of the sprite line-buffer write/clear logic.
- Accepts 8-pixel 4bpp graphics words fetched from CROM, together with a palette attribute.
- Serialises the pixels at the pixel-enable rate and drives the X address counter.
- Produces per-pixel write strobes split by even/odd line-buffer bank (DOTA/DOTB). Transparent pixels are skipped without writing.
- Includes a one-entry hold register, so the next CROM word can be fetched while the current word is being shifted out.

---
 rtl/sprite_pixel_serializer.sv | 168 ++++++++++++++++
 tb/tb_sprite_pixel_serializer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_pixel_serializer.sv
// Sprite pixel serializer: buffers one 8-pixel CROM word, shifts pixels out on CE_PIX,
// and drives line-buffer address/data with per-bank write strobes for non-transparent pixels.
module sprite_pixel_serializer #(
  parameter int PIX_BITS = 4,
  parameter int PAL_BITS = 7,
  parameter int X_BITS   = 9
) (
  input  logic                         clk,
  input  logic                         nRESET,
  input  logic                         CE_PIX,
  input  logic                         LOAD,
  output logic                         READY,
  input  logic [31:0]                  CROM_DATA,
  input  logic [PAL_BITS-1:0]          PAL_IN,
  input  logic                         TILE_FLIPX,
  input  logic                         DISP_HFLIP,
  input  logic                         nLOAD_X,
  input  logic [X_BITS-1:0]            X_LOAD_VAL,
  output logic [X_BITS-1:0]            LB_ADDR,
  output logic [PAL_BITS+PIX_BITS-1:0] LB_DATA,
  output logic                         LB_WE_EVEN,
  output logic                         LB_WE_ODD,
  output logic                         BUSY
);
  localparam int NPIX = 32 / PIX_BITS;

  typedef enum logic {IDLE, SHIFT} state_t;

  function automatic logic [31:0] flip_word(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < NPIX; i++)
      r[i*PIX_BITS +: PIX_BITS] = w[(NPIX-1-i)*PIX_BITS +: PIX_BITS];
    return r;
  endfunction

  function automatic logic [X_BITS-1:0] x_step(input logic [X_BITS-1:0] x, input logic dec);
    return dec ? x - 1'b1 : x + 1'b1;
  endfunction

  state_t                         state_q, state_d;
  logic [2:0]                     cnt_q, cnt_d;
  logic [31:0]                    sh_q, sh_d;
  logic [PAL_BITS-1:0]            sh_pal_q, sh_pal_d;
  logic [31:0]                    hold_q, hold_d;
  logic [PAL_BITS-1:0]            hold_pal_q, hold_pal_d;
  logic                           hold_flip_q, hold_flip_d;
  logic                           full_q, full_d;
  logic [X_BITS-1:0]              x_q, x_d;
  logic [X_BITS-1:0]              addr_q, addr_d;
  logic [PAL_BITS+PIX_BITS-1:0]   data_q, data_d;
  logic                           we_even_q, we_even_d;
  logic                           we_odd_q, we_odd_d;
  logic                           busy_q, busy_d;

  logic                           emit;
  logic [PIX_BITS-1:0]            pix;
  logic [PAL_BITS-1:0]            pal_v;
  logic [31:0]                    word;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    sh_pal_d    = sh_pal_q;
    hold_d      = hold_q;
    hold_pal_d  = hold_pal_q;
    hold_flip_d = hold_flip_q;
    full_d      = full_q;
    x_d         = x_q;
    addr_d      = addr_q;
    data_d      = data_q;
    we_even_d   = 1'b0;
    we_odd_d    = 1'b0;
    emit        = 1'b0;
    pix         = '0;
    pal_v       = sh_pal_q;
    word        = hold_flip_q ? flip_word(hold_q) : hold_q;

    // The transfer edge emits pixel 0 straight from the hold register so runs stay gapless.
    if (CE_PIX) begin
      case (state_q)
        IDLE: if (full_q) begin
          emit     = 1'b1;
          pix      = word[31 -: PIX_BITS];
          pal_v    = hold_pal_q;
          sh_d     = word << PIX_BITS;
          sh_pal_d = hold_pal_q;
          cnt_d    = 3'd1;
          full_d   = 1'b0;
          state_d  = SHIFT;
        end
        SHIFT: begin
          emit  = 1'b1;
          pix   = sh_q[31 -: PIX_BITS];
          sh_d  = sh_q << PIX_BITS;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (LOAD && !full_q) begin
      hold_d      = CROM_DATA;
      hold_pal_d  = PAL_IN;
      hold_flip_d = TILE_FLIPX;
      full_d      = 1'b1;
    end

    if (emit) begin
      addr_d = x_q;
      data_d = {pal_v, pix};
      if (pix != '0) begin
        we_even_d = ~x_q[0];
        we_odd_d  = x_q[0];
      end
      x_d = x_step(x_q, DISP_HFLIP);
    end

    // A load wins over the step; the pixel on this edge already took the old address.
    if (CE_PIX && !nLOAD_X) x_d = X_LOAD_VAL;

    busy_d = (state_d == SHIFT) || full_d;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      sh_pal_q    <= '0;
      hold_q      <= '0;
      hold_pal_q  <= '0;
      hold_flip_q <= 1'b0;
      full_q      <= 1'b0;
      x_q         <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      we_even_q   <= 1'b0;
      we_odd_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      sh_pal_q    <= sh_pal_d;
      hold_q      <= hold_d;
      hold_pal_q  <= hold_pal_d;
      hold_flip_q <= hold_flip_d;
      full_q      <= full_d;
      x_q         <= x_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_even_q   <= we_even_d;
      we_odd_q    <= we_odd_d;
      busy_q      <= busy_d;
    end
  end

  assign READY      = ~full_q;
  assign BUSY       = busy_q;
  assign LB_ADDR    = addr_q;
  assign LB_DATA    = data_q;
  assign LB_WE_EVEN = we_even_q;
  assign LB_WE_ODD  = we_odd_q;

endmodule

// File: tb/tb_sprite_pixel_serializer.sv
// Scenario bench for sprite_pixel_serializer: expected pixels are queued when a word is
// loaded and compared against strobes captured from the line-buffer outputs.
module tb_sprite_pixel_serializer;
  logic        clk = 1'b0;
  logic        nRESET;
  logic        CE_PIX;
  logic        LOAD;
  logic        READY;
  logic [31:0] CROM_DATA;
  logic [6:0]  PAL_IN;
  logic        TILE_FLIPX;
  logic        DISP_HFLIP;
  logic        nLOAD_X;
  logic [8:0]  X_LOAD_VAL;
  logic [8:0]  LB_ADDR;
  logic [10:0] LB_DATA;
  logic        LB_WE_EVEN;
  logic        LB_WE_ODD;
  logic        BUSY;

  sprite_pixel_serializer dut (
    .clk(clk), .nRESET(nRESET), .CE_PIX(CE_PIX), .LOAD(LOAD), .READY(READY),
    .CROM_DATA(CROM_DATA), .PAL_IN(PAL_IN), .TILE_FLIPX(TILE_FLIPX),
    .DISP_HFLIP(DISP_HFLIP), .nLOAD_X(nLOAD_X), .X_LOAD_VAL(X_LOAD_VAL),
    .LB_ADDR(LB_ADDR), .LB_DATA(LB_DATA), .LB_WE_EVEN(LB_WE_EVEN),
    .LB_WE_ODD(LB_WE_ODD), .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  typedef struct { logic [8:0] a; logic [10:0] d; logic e; logic o; int c; } rec_t;
  typedef struct { logic [8:0] a; logic [10:0] d; } exp_t;

  rec_t obs[$];
  exp_t exp_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(negedge clk) begin
    rec_t r;
    cyc++;
    if (LB_WE_EVEN || LB_WE_ODD) begin
      r.a = LB_ADDR; r.d = LB_DATA; r.e = LB_WE_EVEN; r.o = LB_WE_ODD; r.c = cyc;
      obs.push_back(r);
    end
  end

  // Reference pixel order and address walk, queueing only non-transparent pixels.
  task automatic expect_word(input logic [31:0] w, input logic [6:0] pal, input logic flip,
                             input logic [8:0] x0, input logic dec);
    logic [3:0] p;
    logic [8:0] x;
    exp_t e;
    x = x0;
    for (int i = 0; i < 8; i++) begin
      p = flip ? w[4*i +: 4] : w[28-4*i +: 4];
      if (p != 4'h0) begin
        e.a = x; e.d = {pal, p};
        exp_q.push_back(e);
      end
      x = dec ? x - 9'd1 : x + 9'd1;
    end
  endtask

  task automatic set_x(input logic [8:0] v);
    @(posedge clk); #1;
    CE_PIX = 1'b1; nLOAD_X = 1'b0; X_LOAD_VAL = v;
    @(posedge clk); #1;
    nLOAD_X = 1'b1;
  endtask

  task automatic load_word(input logic [31:0] w, input logic [6:0] pal, input logic flip);
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (READY === 1'b1) break;
    end
    if (k == 50) begin
      n_tests++; n_fail++;
      $display("FAIL load_wait READY never rose for word %h", w);
    end
    LOAD = 1'b1; CROM_DATA = w; PAL_IN = pal; TILE_FLIPX = flip;
    @(posedge clk); #1;
    LOAD = 1'b0;
  endtask

  task automatic test_reset;
    rec_t o;
    int k;
    n_tests++;
    if (READY !== 1'b1 || BUSY !== 1'b0 || LB_WE_EVEN !== 1'b0 || LB_WE_ODD !== 1'b0 ||
        LB_ADDR !== 9'h0 || LB_DATA !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_state rdy=%b busy=%b we=%b%b addr=%h data=%h required 1 0 00 000 000",
               READY, BUSY, LB_WE_EVEN, LB_WE_ODD, LB_ADDR, LB_DATA);
    end
    @(posedge clk); #1 nRESET = 1'b1;
    obs.delete();
    load_word(32'hFFFFFFFF, 7'h01, 1'b0);
    for (k = 0; k < 30; k++) begin
      @(negedge clk); #1;
      if (obs.size() >= 3) break;
    end
    n_tests++;
    if (obs.size() < 3) begin
      n_fail++;
      $display("FAIL reset_pre strobes=%0d required 3", obs.size());
    end
    #1 nRESET = 1'b0;
    #1;
    n_tests++;
    if (LB_WE_EVEN !== 1'b0 || LB_WE_ODD !== 1'b0 || READY !== 1'b1 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid we=%b%b rdy=%b busy=%b required 00 1 0",
               LB_WE_EVEN, LB_WE_ODD, READY, BUSY);
    end
    @(posedge clk); #1 nRESET = 1'b1;
    obs.delete();
    repeat (20) @(negedge clk);
    #1;
    n_tests++;
    if (obs.size() != 0) begin
      o = obs[0];
      n_fail++;
      $display("FAIL reset_after strobes=%0d first addr=%h required 0 strobes", obs.size(), o.a);
    end
    obs.delete();
  endtask

  task automatic test_sequential;
    rec_t o;
    exp_t x;
    int n;
    obs.delete(); exp_q.delete();
    set_x(9'h010);
    expect_word(32'h12345678, 7'h05, 1'b0, 9'h010, 1'b0);
    load_word(32'h12345678, 7'h05, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    n_tests++;
    if (obs.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL seq_count got %0d strobes required %0d", obs.size(), exp_q.size());
    end
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      o = obs.pop_front(); x = exp_q.pop_front();
      n_tests++;
      if (o.a !== x.a || o.d !== x.d || o.e !== ~x.a[0] || o.o !== x.a[0]) begin
        n_fail++;
        $display("FAIL seq_pix%0d addr=%h data=%h we=%b%b required addr=%h data=%h",
                 i, o.a, o.d, o.e, o.o, x.a, x.d);
      end
    end
  endtask

  task automatic test_flipx_wrap;
    rec_t o;
    exp_t x;
    int n;
    obs.delete(); exp_q.delete();
    set_x(9'h1FE);
    expect_word(32'h10000002, 7'h33, 1'b1, 9'h1FE, 1'b0);
    load_word(32'h10000002, 7'h33, 1'b1);
    repeat (20) @(negedge clk);
    #1;
    n_tests++;
    if (obs.size() != 2 || exp_q.size() != 2) begin
      n_fail++;
      $display("FAIL flipx_count got %0d strobes required 2", obs.size());
    end
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      o = obs.pop_front(); x = exp_q.pop_front();
      n_tests++;
      if (o.a !== x.a || o.d !== x.d || o.e !== ~x.a[0] || o.o !== x.a[0]) begin
        n_fail++;
        $display("FAIL flipx_pix%0d addr=%h data=%h we=%b%b required addr=%h data=%h",
                 i, o.a, o.d, o.e, o.o, x.a, x.d);
      end
    end
  endtask

  task automatic test_hflip;
    rec_t o;
    exp_t x;
    int n;
    obs.delete(); exp_q.delete();
    DISP_HFLIP = 1'b1;
    set_x(9'h001);
    expect_word(32'hFFFFFFFF, 7'h7F, 1'b0, 9'h001, 1'b1);
    load_word(32'hFFFFFFFF, 7'h7F, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    DISP_HFLIP = 1'b0;
    n_tests++;
    if (obs.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL hflip_count got %0d strobes required %0d", obs.size(), exp_q.size());
    end
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      o = obs.pop_front(); x = exp_q.pop_front();
      n_tests++;
      if (o.a !== x.a || o.d !== x.d || o.e !== ~x.a[0] || o.o !== x.a[0]) begin
        n_fail++;
        $display("FAIL hflip_pix%0d addr=%h data=%h we=%b%b required addr=%h data=%h",
                 i, o.a, o.d, o.e, o.o, x.a, x.d);
      end
    end
  endtask

  task automatic test_back_to_back;
    rec_t o, prev;
    exp_t x;
    int n;
    int k;
    obs.delete(); exp_q.delete();
    set_x(9'h100);
    expect_word(32'h9ABCDEF1, 7'h02, 1'b0, 9'h100, 1'b0);
    expect_word(32'h2468ACE3, 7'h03, 1'b0, 9'h108, 1'b0);
    load_word(32'h9ABCDEF1, 7'h02, 1'b0);
    load_word(32'h2468ACE3, 7'h03, 1'b0);
    LOAD = 1'b1; CROM_DATA = 32'h55555555; PAL_IN = 7'h04; TILE_FLIPX = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (READY !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_ready_full cycle%0d ready=%b required 0", i, READY);
      end
    end
    LOAD = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((LB_WE_EVEN || LB_WE_ODD) && LB_DATA == {7'h03, 4'h2}) break;
      n_tests++;
      if (READY !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_ready_early ready=%b required 0 before transfer", READY);
      end
    end
    n_tests++;
    if (k == 20 || READY !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready_rise ready=%b waited=%0d required 1 at first pixel of word 2",
               READY, k);
    end
    repeat (20) @(negedge clk);
    #1;
    n_tests++;
    if (obs.size() != 16) begin
      n_fail++;
      $display("FAIL b2b_count got %0d strobes required 16", obs.size());
    end
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      o = obs.pop_front(); x = exp_q.pop_front();
      n_tests++;
      if (o.a !== x.a || o.d !== x.d || o.e !== ~x.a[0] || o.o !== x.a[0] ||
          (i > 0 && o.c != prev.c + 1)) begin
        n_fail++;
        $display("FAIL b2b_pix%0d addr=%h data=%h we=%b%b cyc=%0d required addr=%h data=%h gapless",
                 i, o.a, o.d, o.e, o.o, o.c, x.a, x.d);
      end
      prev = o;
    end
  endtask

  task automatic test_ce_slow;
    rec_t o, prev;
    exp_t x;
    int n;
    obs.delete(); exp_q.delete();
    set_x(9'h010);
    CE_PIX = 1'b0;
    expect_word(32'h12345678, 7'h05, 1'b0, 9'h010, 1'b0);
    load_word(32'h12345678, 7'h05, 1'b0);
    for (int i = 0; i < 48; i++) begin
      CE_PIX = (i % 4 == 0);
      @(posedge clk); #1;
    end
    CE_PIX = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    n_tests++;
    if (obs.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL ce_count got %0d strobes required %0d", obs.size(), exp_q.size());
    end
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      o = obs.pop_front(); x = exp_q.pop_front();
      n_tests++;
      if (o.a !== x.a || o.d !== x.d || o.e !== ~x.a[0] || o.o !== x.a[0] ||
          (i > 0 && o.c != prev.c + 4)) begin
        n_fail++;
        $display("FAIL ce_pix%0d addr=%h data=%h we=%b%b cyc=%0d required addr=%h data=%h spacing 4",
                 i, o.a, o.d, o.e, o.o, o.c, x.a, x.d);
      end
      prev = o;
    end
  endtask

  initial begin
    nRESET = 1'b0; CE_PIX = 1'b1; LOAD = 1'b0; CROM_DATA = '0; PAL_IN = '0;
    TILE_FLIPX = 1'b0; DISP_HFLIP = 1'b0; nLOAD_X = 1'b1; X_LOAD_VAL = '0;
    #12;
    test_reset;
    test_sequential;
    test_flipx_wrap;
    test_hflip;
    test_back_to_back;
    test_ce_slow;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end
endmodule
